// File: rtl/seven_seg_pkg.sv
// Shared definitions for the multiplexed seven-segment display driver:
// hex segment table, slot state encoding and pin polarity helper.
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } slot_state_e;

    // Active-high patterns, bit 6 = g ... bit 0 = a
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern,
                                                input logic       active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational nibble to active-high seven-segment pattern lookup.
module seven_seg_hex_decoder
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with blanking slots,
// leading-zero suppression and frame-synchronous (tear-free) updates.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter  int NUM_DIGITS     = 4,
    parameter  int CLK_DIV        = 50000,
    parameter  int BLANK_CYCLES   = 4,
    parameter  bit SEG_ACTIVE_LOW = 1'b1,
    parameter  bit AN_ACTIVE_LOW  = 1'b1,
    localparam int IDX_W          = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lzb,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    seg_dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [IDX_W-1:0]        scan_idx,
    output logic                    frame_done
);

    localparam int                DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  BLANK_END = DIV_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0]  SCAN_MAX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};
    localparam slot_state_e       RESET_STATE = (BLANK_CYCLES > 0) ? BLANK : ON;

    logic [DIV_W-1:0]        div_cnt, div_nxt;
    logic [IDX_W-1:0]        scan_nxt;
    logic                    frame_done_nxt;
    slot_state_e             state, state_nxt;

    logic [4*NUM_DIGITS-1:0] pend_value, disp_value;
    logic [NUM_DIGITS-1:0]   pend_dp, pend_en, disp_dp, disp_en;
    logic                    pend_lzb, disp_lzb;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_nib;
    logic                    cur_dp, cur_en, cur_blank;
    logic [6:0]              cur_pattern;
    logic [NUM_DIGITS-1:0]   an_ah;
    logic [6:0]              seg_ah;
    logic                    dp_ah;

    // frame_done is registered from next-state so it lines up with the last slot cycle
    always_comb begin
        div_nxt  = (div_cnt == DIV_MAX) ? '0 : div_cnt + 1'b1;
        scan_nxt = scan_idx;
        if (div_cnt == DIV_MAX) begin
            scan_nxt = (scan_idx == SCAN_MAX) ? '0 : scan_idx + 1'b1;
        end
        frame_done_nxt = (div_nxt == DIV_MAX) && (scan_nxt == SCAN_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            scan_idx   <= '0;
            frame_done <= 1'b0;
        end else begin
            div_cnt    <= div_nxt;
            scan_idx   <= scan_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RESET_STATE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = (div_nxt < BLANK_END) ? BLANK : ON;
    end

    // Display register only changes at the frame boundary; a coincident load bypasses pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_lzb   <= 1'b0;
            disp_value <= '0;
            disp_dp    <= '0;
            disp_en    <= '0;
            disp_lzb   <= 1'b0;
        end else begin
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_en    <= digit_en;
                pend_lzb   <= lzb;
            end
            if (frame_done) begin
                disp_value <= load ? value    : pend_value;
                disp_dp    <= load ? dp       : pend_dp;
                disp_en    <= load ? digit_en : pend_en;
                disp_lzb   <= load ? lzb      : pend_lzb;
            end
        end
    end

    always_comb begin : lzb_mask
        logic run;
        run      = disp_lzb;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            run         = run && (disp_value[4*i +: 4] == 4'h0);
            lz_blank[i] = run;
        end
    end

    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                cur_nib   = disp_value[4*i +: 4];
                cur_dp    = disp_dp[i];
                cur_en    = disp_en[i];
                cur_blank = lz_blank[i];
            end
        end
    end

    seven_seg_hex_decoder u_hex_decoder (
        .nibble  (cur_nib),
        .pattern (cur_pattern)
    );

    always_comb begin
        an_ah  = '0;
        seg_ah = 7'h00;
        dp_ah  = 1'b0;
        if (state == ON) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                an_ah[i] = (scan_idx == IDX_W'(i));
            end
            seg_ah = (cur_en && !cur_blank) ? cur_pattern : 7'h00;
            dp_ah  = cur_en && cur_dp;
        end
    end

    // Output stage: one cycle behind the scan state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an     <= AN_OFF;
            seg    <= seg_polarity(7'h00, SEG_ACTIVE_LOW);
            seg_dp <= SEG_ACTIVE_LOW;
        end else begin
            an     <= an_ah ^ AN_OFF;
            seg    <= seg_polarity(seg_ah, SEG_ACTIVE_LOW);
            seg_dp <= dp_ah ^ SEG_ACTIVE_LOW;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: cycle-accurate reference model feeds a scoreboard of
// expected pin states, plus targeted checks of decode, LZB and tear-free loads.
module tb_seven_seg_scan_driver;

    localparam int ND    = 4;
    localparam int CD    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * CD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  digit_en = '0;
    logic        lzb = 1'b0;
    logic        load = 1'b0;
    logic [6:0]  seg;
    logic        seg_dp;
    logic [3:0]  an;
    logic [1:0]  scan_idx;
    logic        frame_done;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .CLK_DIV        (CD),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .lzb        (lzb),
        .load       (load),
        .seg        (seg),
        .seg_dp     (seg_dp),
        .an         (an),
        .scan_idx   (scan_idx),
        .frame_done (frame_done)
    );

    localparam logic [6:0] HEX_AH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };
    localparam logic [6:0] HEX_INV [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          n_checks = 0;
    int          n_errors = 0;
    int          c = 0;
    logic [15:0] pend_v = '0, disp_v = '0;
    logic [3:0]  pend_dp = '0, disp_dp = '0, pend_en = '0, disp_en = '0;
    logic        pend_lzb = 1'b0, disp_lzb = 1'b0;
    logic [14:0] sb_q [$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, c);
        end
    endtask

    // Pins expected during cycle cc+1, from the scan position of cycle cc
    function automatic logic [14:0] model_out(input int cc);
        int         pos, dig, sub, hi;
        logic [6:0] s;
        logic       d, blank;
        logic [3:0] a, nib;
        logic [1:0] sc;
        pos = cc % FRAME;
        dig = pos / CD;
        sub = pos % CD;
        a = 4'hF;
        s = 7'h00;
        d = 1'b0;
        if (sub >= BC) begin
            a  = ~(4'b0001 << dig);
            hi = -1;
            for (int i = 0; i < ND; i++) if (disp_v[4*i +: 4] != 4'h0) hi = i;
            blank = disp_lzb && (dig != 0) && (dig > hi);
            nib   = disp_v[4*dig +: 4];
            if (disp_en[dig] && !blank) s = HEX_AH[nib];
            d = disp_en[dig] && disp_dp[dig];
        end
        sc = 2'(((cc + 1) / CD) % ND);
        return {sc, (((cc + 1) % FRAME) == FRAME - 1), ~d, a, ~s};
    endfunction

    task automatic step(input logic ld);
        logic [14:0] exp_w, got_w;
        load = ld;
        sb_q.push_back(model_out(c));
        if (c % FRAME == FRAME - 1) begin
            disp_v   = ld ? value    : pend_v;
            disp_dp  = ld ? dp       : pend_dp;
            disp_en  = ld ? digit_en : pend_en;
            disp_lzb = ld ? lzb      : pend_lzb;
        end
        if (ld) begin
            pend_v = value; pend_dp = dp; pend_en = digit_en; pend_lzb = lzb;
        end
        @(posedge clk);
        #1;
        load = 1'b0;
        c++;
        exp_w = sb_q.pop_front();
        got_w = {scan_idx, frame_done, seg_dp, an, seg};
        check_val("scan_pins", 32'(got_w), 32'(exp_w));
    endtask

    task automatic run_to(input int pos);
        int guard = 0;
        while ((c % FRAME) != pos && guard < 2 * FRAME) begin
            step(1'b0);
            guard++;
        end
        if ((c % FRAME) != pos) check_val("run_to_timeout", 32'(c % FRAME), 32'(pos));
    endtask

    task automatic next_frame_at(input int pos);
        run_to(FRAME - 1);
        step(1'b0);
        run_to(pos);
    endtask

    task automatic set_load(input logic [15:0] v, input logic [3:0] d,
                            input logic [3:0] en, input logic z);
        value = v; dp = d; digit_en = en; lzb = z;
        step(1'b1);
    endtask

    task automatic restart_model();
        c = 0;
        pend_v = '0; pend_dp = '0; pend_en = '0; pend_lzb = 1'b0;
        disp_v = '0; disp_dp = '0; disp_en = '0; disp_lzb = 1'b0;
        sb_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, guard;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_an", 32'(an), 32'h0F);
        check_val("rst_seg", 32'(seg), 32'h7F);
        check_val("rst_dp", 32'(seg_dp), 32'h1);
        check_val("rst_fd", 32'(frame_done), 32'h0);
        #2 rst_n = 1'b1;
        restart_model();

        run_to(2);
        check_val("pre_on_an", 32'(an), 32'h0F);
        step(1'b0);
        check_val("first_on_an", 32'(an), 32'h0E);

        for (int n = 0; n < 16; n++) begin
            set_load(16'(n), 4'b0000, 4'b0001, 1'b0);
            next_frame_at(4);
            check_val($sformatf("hex_%0h", n), 32'(seg), 32'(HEX_INV[n]));
        end

        set_load(16'h1234, 4'b0000, 4'hF, 1'b0);
        next_frame_at(4);
        check_val("scan_an0", 32'({an, seg}), 32'({4'hE, 7'h19}));
        run_to(12);
        check_val("scan_an1", 32'({an, seg}), 32'({4'hD, 7'h30}));
        run_to(20);
        check_val("scan_an2", 32'({an, seg}), 32'({4'hB, 7'h24}));
        run_to(28);
        check_val("scan_an3", 32'({an, seg}), 32'({4'h7, 7'h79}));
        run_to(FRAME - 1);
        check_val("fd_pulse", 32'(frame_done), 32'h1);
        t1 = c;
        step(1'b0);
        guard = 0;
        while (!frame_done && guard < 2 * FRAME) begin
            step(1'b0);
            guard++;
        end
        check_val("fd_period", 32'(c - t1), 32'(FRAME));

        run_to(10);
        set_load(16'hAAAA, 4'b0000, 4'hF, 1'b0);
        run_to(28);
        check_val("tear_old", 32'(seg), 32'h79);
        next_frame_at(4);
        check_val("tear_new", 32'(seg), 32'h08);
        value = 16'hBBBB;
        run_to(FRAME - 1);
        step(1'b1);
        run_to(4);
        check_val("bypass_new", 32'(seg), 32'h03);
        next_frame_at(4);
        check_val("bypass_pend", 32'(seg), 32'h03);

        set_load(16'h0050, 4'b1000, 4'hF, 1'b1);
        next_frame_at(4);
        check_val("lzb_d0", 32'({seg_dp, seg}), 32'({1'b1, 7'h40}));
        run_to(12);
        check_val("lzb_d1", 32'({seg_dp, seg}), 32'({1'b1, 7'h12}));
        run_to(20);
        check_val("lzb_d2", 32'({seg_dp, seg}), 32'({1'b1, 7'h7F}));
        run_to(28);
        check_val("lzb_d3_dp", 32'({an, seg_dp, seg}), 32'({4'h7, 1'b0, 7'h7F}));
        set_load(16'h0000, 4'b0000, 4'hF, 1'b1);
        next_frame_at(4);
        check_val("lzb0_d0", 32'(seg), 32'h40);
        run_to(12);
        check_val("lzb0_d1", 32'(seg), 32'h7F);
        run_to(28);
        check_val("lzb0_d3", 32'(seg), 32'h7F);

        set_load(16'h1234, 4'b1111, 4'b1101, 1'b0);
        next_frame_at(12);
        check_val("en_off", 32'({an, seg_dp, seg}), 32'({4'hD, 1'b1, 7'h7F}));
        run_to(20);
        check_val("en_on_dp", 32'({seg_dp, seg}), 32'({1'b0, 7'h24}));

        run_to(13);
        check_val("pre_rst_an", 32'(an), 32'h0D);
        #1 rst_n = 1'b0;
        #1;
        check_val("async_rst", 32'({an, seg_dp, seg, frame_done}), 32'({4'hF, 1'b1, 7'h7F, 1'b0}));
        repeat (2) @(posedge clk);
        #1;
        check_val("hold_rst_idx", 32'({an, scan_idx}), 32'({4'hF, 2'b00}));
        #2 rst_n = 1'b1;
        restart_model();
        run_to(3);
        check_val("restart_an", 32'(an), 32'h0E);
        run_to(11);
        check_val("restart_d1", 32'(an), 32'h0D);
        run_to(FRAME - 1);
        step(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
